lb_regbank_gen: RTL and testbench



---
 rtl/lb_regbank_gen_if.sv | 27 ++
 rtl/lb_regbank_gen.sv | 215 +++++++++++++++++++++
 tb/tb_lb_regbank_gen.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/lb_regbank_gen_if.sv
// Local-bus port bundle for lb_regbank_gen: single-cycle write request plus a
// read path whose enable, last-beat flag and address arrive as delay lines.
interface lb_regbank_gen_if #(
  parameter int unsigned ADDR_WIDTH = 24,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned READDELAY  = 1
) ();
  logic                              wren;
  logic [ADDR_WIDTH-1:0]             waddr;
  logic [DATA_WIDTH-1:0]             wdata;
  logic [READDELAY+1:0]              rden;
  logic [READDELAY+1:0]              rdenlast;
  logic [(READDELAY+1)*ADDR_WIDTH-1:0] raddr;
  logic [DATA_WIDTH-1:0]             rdata;
  logic                              rvalid;
  logic                              rvalidlast;

  modport master (
    output wren, waddr, wdata, rden, rdenlast, raddr,
    input  rdata, rvalid, rvalidlast
  );

  modport slave (
    input  wren, waddr, wdata, rden, rdenlast, raddr,
    output rdata, rvalid, rvalidlast
  );
endinterface

// File: rtl/lb_regbank_gen.sv
// Generic local-bus register bank: NREG registers at BASE..BASE+NREG-1 plus a
// commit word at BASE+NREG. Each entry is RW, RW self-clearing (pulse) or
// read-only status. Optional feature macro LB_REGBANK_SHADOW_EN: RW writes land
// in a shadow copy that is transferred to the active registers by writing the
// commit word. Without the macro, writes update the active registers directly.
module lb_regbank_gen #(
  parameter int unsigned                   NREG       = 16,
  parameter int unsigned                   DATA_WIDTH = 32,
  parameter int unsigned                   ADDR_WIDTH = 24,
  parameter int unsigned                   READDELAY  = 1,
  parameter logic [ADDR_WIDTH-1:0]         BASE       = '0,
  parameter logic [NREG-1:0]               RW_MASK    = '1,
  parameter logic [NREG-1:0]               PULSE_MASK = '0,
  parameter logic [NREG*DATA_WIDTH-1:0]    INIT       = '0
) (
  input  logic                             clk,
  input  logic                             reset,
  lb_regbank_gen_if.slave                  bus_io,
  output logic [NREG*DATA_WIDTH-1:0]       regs,
  output logic [NREG-1:0]                  stb,
  input  logic [NREG*DATA_WIDTH-1:0]       status,
  output logic                             commit_pending
);

  localparam int unsigned IdxW  = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int unsigned WideW = (DATA_WIDTH > 32) ? DATA_WIDTH : 32;
  localparam logic [ADDR_WIDTH:0] NregA = (ADDR_WIDTH+1)'(NREG);

  typedef struct packed {
    logic            reg_hit;
    logic            commit_hit;
    logic [IdxW-1:0] idx;
  } dec_t;

  // Offset is computed one bit wider so BASE near the top of the map can't wrap.
  function automatic dec_t decode(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH:0] off;
    dec_t d;
    off          = {1'b0, addr} - {1'b0, BASE};
    d.reg_hit    = (addr >= BASE) && (off < NregA);
    d.commit_hit = (addr >= BASE) && (off == NregA);
    d.idx        = off[IdxW-1:0];
    return d;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] init_of(input int unsigned i);
    return INIT[i*DATA_WIDTH +: DATA_WIDTH];
  endfunction

  // ---------------------------------------------------------------------------
  // Write pipeline: request registered once, decoded and applied the next cycle
  // ---------------------------------------------------------------------------
  logic                  wr_vld_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  dec_t                  wr_dec;
  logic                  wr_rw;

  // Capture the bus write; reset drops any request in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_vld_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_vld_q  <= bus_io.wren;
      if (bus_io.wren) begin
        wr_addr_q <= bus_io.waddr;
        wr_data_q <= bus_io.wdata;
      end
    end
  end

  assign wr_dec = decode(wr_addr_q);
  assign wr_rw  = wr_vld_q && wr_dec.reg_hit && RW_MASK[wr_dec.idx];

  // One-cycle strobe for the RW register being written this cycle.
  always_comb begin
    stb = '0;
    if (wr_rw) stb[wr_dec.idx] = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Register storage
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] act_q [NREG];
  logic [DATA_WIDTH-1:0] act_d [NREG];
  logic [DATA_WIDTH-1:0] status_a [NREG];

  for (genvar g = 0; g < NREG; g++) begin : g_map
    assign regs[g*DATA_WIDTH +: DATA_WIDTH] = act_q[g];
    assign status_a[g]                      = status[g*DATA_WIDTH +: DATA_WIDTH];
  end

`ifdef LB_REGBANK_SHADOW_EN
  logic                  wr_commit;
  logic [DATA_WIDTH-1:0] sh_q [NREG];
  logic [DATA_WIDTH-1:0] sh_d [NREG];
  logic [31:0]           cnt_q, cnt_d;
  logic                  pend_q, pend_d;

  assign wr_commit = wr_vld_q && wr_dec.commit_hit;

  // Next state: pulse regs fall back to INIT, RW writes go to the shadow,
  // a commit copies every non-pulse RW shadow entry into the active set.
  always_comb begin
    act_d  = act_q;
    sh_d   = sh_q;
    cnt_d  = cnt_q;
    pend_d = pend_q;
    for (int i = 0; i < NREG; i++) begin
      if (PULSE_MASK[i]) act_d[i] = init_of(i);
    end
    if (wr_commit) begin
      for (int i = 0; i < NREG; i++) begin
        if (RW_MASK[i] && !PULSE_MASK[i]) act_d[i] = sh_q[i];
      end
      cnt_d  = cnt_q + 32'd1;
      pend_d = 1'b0;
    end
    if (wr_rw) begin
      if (PULSE_MASK[wr_dec.idx]) begin
        act_d[wr_dec.idx] = wr_data_q;
      end else begin
        sh_d[wr_dec.idx] = wr_data_q;
        pend_d           = 1'b1;
      end
    end
  end

  // Active, shadow, commit counter and pending flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        act_q[i] <= init_of(i);
        sh_q[i]  <= init_of(i);
      end
      cnt_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      act_q  <= act_d;
      sh_q   <= sh_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

  assign commit_pending = pend_q;
`else
  // Next state: pulse regs fall back to INIT, RW writes land directly.
  always_comb begin
    act_d = act_q;
    for (int i = 0; i < NREG; i++) begin
      if (PULSE_MASK[i]) act_d[i] = init_of(i);
    end
    if (wr_rw) act_d[wr_dec.idx] = wr_data_q;
  end

  // Active register set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) act_q[i] <= init_of(i);
    end else begin
      act_q <= act_d;
    end
  end

  assign commit_pending = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Read path: sample address at delay stage READDELAY, present data one later
  // ---------------------------------------------------------------------------
  logic                  rd_sample;
  logic [ADDR_WIDTH-1:0] rd_addr;
  dec_t                  rd_dec;
  logic [WideW-1:0]      rd_word;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  assign rd_sample = bus_io.rden[READDELAY];
  assign rd_addr   = bus_io.raddr[READDELAY*ADDR_WIDTH +: ADDR_WIDTH];
  assign rd_dec    = decode(rd_addr);

  // Read mux; rdata holds when nothing is sampled.
  always_comb begin
    rd_word = WideW'(32'hdeadbeef);
    if (rd_dec.reg_hit) begin
      if (RW_MASK[rd_dec.idx]) rd_word = WideW'(act_q[rd_dec.idx]);
      else                     rd_word = WideW'(status_a[rd_dec.idx]);
    end else if (rd_dec.commit_hit) begin
`ifdef LB_REGBANK_SHADOW_EN
      rd_word = WideW'(cnt_q);
`else
      rd_word = '0;
`endif
    end
    rdata_d = rdata_q;
    if (rd_sample) rdata_d = rd_word[DATA_WIDTH-1:0];
  end

  // Read data register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  assign bus_io.rdata      = rdata_q;
  assign bus_io.rvalid     = bus_io.rden[READDELAY+1];
  assign bus_io.rvalidlast = bus_io.rdenlast[READDELAY+1];

  // Delay-line stages other than the sampled ones are not needed here.
  logic unused_bits;
  assign unused_bits = ^{bus_io.rden, bus_io.rdenlast, bus_io.raddr, wr_dec.commit_hit};

endmodule

// File: tb/tb_lb_regbank_gen.sv
// Directed bench for lb_regbank_gen (READDELAY=3, reg 7 read-only, reg 5 pulse).
// Expectations adapt when LB_REGBANK_SHADOW_EN is defined.
module tb_lb_regbank_gen;
  localparam int unsigned NR = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 24;
  localparam int unsigned RD = 3;
  localparam logic [AW-1:0] BaseA     = 24'h000100;
  localparam logic [NR-1:0] RwMask    = 16'hff7f;
  localparam logic [NR-1:0] PulseMask = 16'h0020;

  function automatic logic [NR*DW-1:0] mk_init();
    logic [NR*DW-1:0] r;
    for (int i = 0; i < NR; i++) r[i*DW +: DW] = 32'h1000 + 32'(i);
    return r;
  endfunction

  localparam logic [NR*DW-1:0] InitP = mk_init();

`ifdef LB_REGBANK_SHADOW_EN
  localparam bit Shadow = 1'b1;
`else
  localparam bit Shadow = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [NR*DW-1:0] regs;
  logic [NR*DW-1:0] status;
  logic [NR-1:0]    stb;
  logic             commit_pending;
  int               n_total = 0;
  int               n_bad = 0;
  logic [DW-1:0]    d;

  lb_regbank_gen_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READDELAY(RD)) bus ();

  lb_regbank_gen #(
    .NREG(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READDELAY(RD), .BASE(BaseA),
    .RW_MASK(RwMask), .PULSE_MASK(PulseMask), .INIT(InitP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus_io(bus),
    .regs(regs),
    .stb(stb),
    .status(status),
    .commit_pending(commit_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // One clock; the read delay lines advance like the bus side would shift them.
  task automatic tick();
    @(posedge clk);
    #1;
    bus.rden     = {bus.rden[RD:0], 1'b0};
    bus.rdenlast = {bus.rdenlast[RD:0], 1'b0};
    bus.raddr    = {bus.raddr[RD*AW-1:0], {AW{1'b0}}};
  endtask

  // Returns in the cycle after the write was sampled (strobe cycle).
  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] v);
    bus.wren  = 1'b1;
    bus.waddr = a;
    bus.wdata = v;
    tick();
    bus.wren  = 1'b0;
  endtask

  // Returns in the cycle rvalid is high.
  task automatic rd(input logic [AW-1:0] a, output logic [DW-1:0] v);
    bus.rden[0]     = 1'b1;
    bus.rdenlast[0] = 1'b1;
    bus.raddr[AW-1:0] = a;
    repeat (RD + 1) tick();
    v = bus.rdata;
  endtask

  initial begin
    bus.wren = 1'b0; bus.waddr = '0; bus.wdata = '0;
    bus.rden = '0; bus.rdenlast = '0; bus.raddr = '0;
    for (int i = 0; i < NR; i++) status[i*DW +: DW] = 32'h5000_0000 + 32'(i);

    tick(); tick();
    reset = 1'b0;
    check("rst_stb", stb, '0);
    check("rst_pend", commit_pending, 1'b0);
    check("rst_rdata", bus.rdata, '0);
    check("rst_rvalid", bus.rvalid, 1'b0);
    check("rst_regs", regs, InitP);

    // Full read sweep
    for (int i = 0; i < NR; i++) begin
      rd(BaseA + AW'(i), d);
      check($sformatf("rd_init%0d", i), d, (i == 7) ? 32'h5000_0007 : 32'h1000 + 32'(i));
    end
    rd(BaseA + 24'd16, d);
    check("rd_commit0", d, 32'h0);
    rd(BaseA + 24'd17, d);
    check("rd_unmap_hi", d, 32'hdeadbeef);
    rd(BaseA - 24'd1, d);
    check("rd_unmap_lo", d, 32'hdeadbeef);

    // Read latency: rvalid exactly READDELAY+1 cycles after rden
    bus.rden[0] = 1'b1; bus.rdenlast[0] = 1'b1; bus.raddr[AW-1:0] = BaseA + 24'd2;
    repeat (RD) tick();
    check("lat_early", bus.rvalid, 1'b0);
    tick();
    check("lat_valid", bus.rvalid, 1'b1);
    check("lat_last", bus.rvalidlast, 1'b1);
    check("lat_data", bus.rdata, 32'h1002);
    tick();
    check("lat_drop", bus.rvalid, 1'b0);
    check("rd_hold", bus.rdata, 32'h1002);

    // RW write to reg 3
    wr(BaseA + 24'd3, 32'h1234);
    check("w3_stb", stb, 16'h0008);
    check("w3_early", regs[3*DW +: DW], 32'h1003);
    tick();
    check("w3_stb_off", stb, '0);
    check("w3_reg", regs[3*DW +: DW], Shadow ? 32'h1003 : 32'h1234);
    check("w3_pend", commit_pending, Shadow);

    // Pulse register 5
    wr(BaseA + 24'd5, 32'h1);
    check("p5_stb", stb, 16'h0020);
    check("p5_pre", regs[5*DW +: DW], 32'h1005);
    tick();
    check("p5_on", regs[5*DW +: DW], 32'h1);
    tick();
    check("p5_back", regs[5*DW +: DW], 32'h1005);

    // Read-only and unmapped writes
    wr(BaseA + 24'd7, 32'hffff);
    check("ro_stb", stb, '0);
    tick();
    check("ro_reg", regs[7*DW +: DW], 32'h1007);
    rd(BaseA + 24'd7, d);
    check("ro_rd", d, 32'h5000_0007);
    wr(BaseA + 24'd17, 32'h5);
    check("unmap_stb", stb, '0);
    wr(BaseA + 24'd16, 32'h5);
    check("commit_stb", stb, '0);
    tick();
    check("commit_pend", commit_pending, 1'b0);
    check("commit_reg3", regs[3*DW +: DW], 32'h1234);
    rd(BaseA + 24'd16, d);
    check("rd_commit1", d, Shadow ? 32'h1 : 32'h0);

    // Back-to-back writes
    wr(BaseA + 24'd0, 32'ha0);
    check("b2b_stb0", stb, 16'h0001);
    wr(BaseA + 24'd1, 32'ha1);
    check("b2b_stb1", stb, 16'h0002);
    check("b2b_r0", regs[0*DW +: DW], Shadow ? 32'h1000 : 32'ha0);
    wr(BaseA + 24'd2, 32'ha2);
    check("b2b_stb2", stb, 16'h0004);
    tick();
    check("b2b_stbx", stb, '0);
    check("b2b_r1", regs[1*DW +: DW], Shadow ? 32'h1001 : 32'ha1);
    check("b2b_r2", regs[2*DW +: DW], Shadow ? 32'h1002 : 32'ha2);

`ifdef LB_REGBANK_SHADOW_EN
    wr(BaseA + 24'd0, 32'ha);
    wr(BaseA + 24'd1, 32'hb);
    tick();
    check("sh_r0_hold", regs[0*DW +: DW], 32'h1000);
    check("sh_pend", commit_pending, 1'b1);
    wr(BaseA + 24'd16, 32'h0);
    check("sh_r0_n1", regs[0*DW +: DW], 32'h1000);
    wr(BaseA + 24'd4, 32'h44);
    check("sh_r0", regs[0*DW +: DW], 32'ha);
    check("sh_r1", regs[1*DW +: DW], 32'hb);
    check("sh_r2", regs[2*DW +: DW], 32'ha2);
    check("sh_pend_clr", commit_pending, 1'b0);
    tick();
    check("sh_pend_after", commit_pending, 1'b1);
    check("sh_r4", regs[4*DW +: DW], 32'h1004);
    rd(BaseA + 24'd16, d);
    check("sh_count", d, 32'h2);
`endif

    // Reset in the middle of the write pipeline
    rd(BaseA + 24'd2, d);
    wr(BaseA + 24'd4, 32'h44);
    check("mid_stb_pre", stb, 16'h0010);
    reset = 1'b1;
    #1;
    check("mid_stb", stb, '0);
    check("mid_regs", regs, InitP);
    check("mid_rdata", bus.rdata, '0);
    check("mid_pend", commit_pending, 1'b0);
    tick();
    reset = 1'b0;
    tick();
    check("mid_regs_after", regs, InitP);
    check("mid_stb_after", stb, '0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
